hqc_rsdecod_bm: RTL and testbench



---
 rtl/hqc_gf256_pkg.sv | 48 ++++
 rtl/gf256_mul.sv | 12 +
 rtl/hqc_rsdecod_bm.sv | 163 ++++++++++++++++
 tb/tb_hqc_rsdecod_bm.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/hqc_gf256_pkg.sv
// GF(2^8) helpers, security-level table and FSM encoding for the HQC RS Berlekamp-Massey stage.
package hqc_gf256_pkg;

  localparam logic [8:0] GF_POLY   = 9'h11D;
  localparam int         DELTA_128 = 15;
  localparam int         DELTA_192 = 16;
  localparam int         DELTA_256 = 29;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DISC = 3'd1,
    ST_COEF = 3'd2,
    ST_UPD  = 3'd3,
    ST_DONE = 3'd4
  } bm_state_e;

  function automatic int delta_of(input int sec);
    if (sec == 192)      return DELTA_192;
    else if (sec == 256) return DELTA_256;
    else                 return DELTA_128;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = t[7] ? ({t[6:0], 1'b0} ^ GF_POLY[7:0]) : {t[6:0], 1'b0};
    end
    return p;
  endfunction

  // Inverse table expressed as a^254 (a^2*a^4*...*a^128); folds to the same 256-entry ROM.
  function automatic logic [7:0] gf256_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier, modulus 0x11D.
module gf256_mul
  import hqc_gf256_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);

  assign o_p = gf_mul(i_a, i_b);

endmodule

// File: rtl/hqc_rsdecod_bm.sv
// Berlekamp-Massey error-locator stage of the HQC RS decoder, fixed latency 2*DELTA*(DELTA+3).
// Optional HQC_BM_DEG_OUT_EN adds deg_o (final L) and fail_o (L > DELTA).
module hqc_rsdecod_bm
  import hqc_gf256_pkg::*;
#(
  parameter  int PARAM_SECURITY = 128,
  localparam int PARAM_DELTA    = delta_of(PARAM_SECURITY),
  localparam int SYN_W          = 16 * PARAM_DELTA,
  localparam int SIG_W          = 8 * (PARAM_DELTA + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [SYN_W-1:0] syn_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic [SIG_W-1:0] sigma_o,
  output logic             done_o
`ifdef HQC_BM_DEG_OUT_EN
  ,
  output logic [7:0]       deg_o,
  output logic             fail_o
`endif
);

  localparam int D  = PARAM_DELTA;
  localparam int NS = 2 * D;
  localparam int JW = $clog2(D + 1);
  localparam logic [D:0][7:0] SIG_ONE = {{D{8'h00}}, 8'h01};

  bm_state_e          r_state, w_nxt;
  logic [NS:1][7:0]   r_syn;
  logic [D:0][7:0]    r_sig;
  logic [D-1:0][7:0]  r_b;
  logic [7:0]         r_l, r_dp, r_d, r_c, r_r;
  logic [JW-1:0]      r_j;
  logic [SIG_W-1:0]   r_sig_out;

  logic [7:0]         w_ma, w_mb, w_mp;
  logic [D:0][7:0]    w_xb, w_cxb, w_sig_nxt;
  logic               w_lchg;
  logic [7:0]         w_l_nxt;

  // Shared multiplier: sigma_j*S_(r-j) during DISC, d*inv(dp) during COEF.
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    if (r_state == ST_COEF) begin
      w_ma = r_d;
      w_mb = gf256_inv(r_dp);
    end else begin
      for (int k = 0; k <= D; k++)
        if (int'(r_j) == k) w_ma = r_sig[k];
      for (int k = 1; k <= NS; k++)
        if (int'(r_r) - int'(r_j) == k) w_mb = r_syn[k];
    end
  end

  gf256_mul u_mul (.i_a(w_ma), .i_b(w_mb), .o_p(w_mp));

  assign w_xb = {r_b, 8'h00};

  for (genvar g = 0; g <= D; g++) begin : g_upd
    gf256_mul u_upd (.i_a(r_c), .i_b(w_xb[g]), .o_p(w_cxb[g]));
  end

  assign w_sig_nxt = r_sig ^ w_cxb;
  assign w_lchg    = (r_d != 8'h00) && ({r_l, 1'b0} <= ({1'b0, r_r} - 9'd1));
  assign w_l_nxt   = r_r - r_l;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_nxt = ST_DISC;
      ST_DISC: if (r_j == JW'(D)) w_nxt = ST_COEF;
      ST_COEF: w_nxt = ST_UPD;
      ST_UPD:  w_nxt = (r_r == 8'(NS)) ? ST_DONE : ST_DISC;
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state == ST_DISC) || (r_state == ST_COEF) || (r_state == ST_UPD);
    done_o = (r_state == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_syn     <= '0;
      r_sig     <= SIG_ONE;
      r_b       <= SIG_ONE[D-1:0];
      r_l       <= '0;
      r_dp      <= 8'h01;
      r_d       <= '0;
      r_c       <= '0;
      r_r       <= 8'h01;
      r_j       <= '0;
      r_sig_out <= SIG_W'(8'h01);
    end else begin
      case (r_state)
        ST_IDLE: if (start_i) begin
          r_syn <= syn_i;
          r_sig <= SIG_ONE;
          r_b   <= SIG_ONE[D-1:0];
          r_l   <= '0;
          r_dp  <= 8'h01;
          r_d   <= '0;
          r_r   <= 8'h01;
          r_j   <= '0;
        end
        ST_DISC: begin
          r_d <= r_d ^ w_mp;
          r_j <= (r_j == JW'(D)) ? '0 : r_j + JW'(1);
        end
        ST_COEF: r_c <= w_mp;
        ST_UPD: begin
          if (r_d != 8'h00) r_sig <= w_sig_nxt;
          if (w_lchg) begin
            r_b  <= r_sig[D-1:0];
            r_l  <= w_l_nxt;
            r_dp <= r_d;
          end else begin
            r_b  <= w_xb[D-1:0];
          end
          r_r <= r_r + 8'd1;
          r_d <= '0;
          // Result register is loaded only on the last iteration; the working sigma never reaches the port.
          if (r_r == 8'(NS)) r_sig_out <= (r_d != 8'h00) ? w_sig_nxt : r_sig;
        end
        default: ;
      endcase
    end
  end

  assign sigma_o = r_sig_out;

`ifdef HQC_BM_DEG_OUT_EN
  logic [7:0] r_deg;
  logic       r_fail;
  logic [7:0] w_l_fin;

  assign w_l_fin = w_lchg ? w_l_nxt : r_l;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_deg  <= '0;
      r_fail <= 1'b0;
    end else if (r_state == ST_UPD && r_r == 8'(NS)) begin
      r_deg  <= w_l_fin;
      r_fail <= (w_l_fin > 8'(D));
    end
  end

  assign deg_o  = r_deg;
  assign fail_o = r_fail;
`endif

endmodule

// File: tb/tb_hqc_rsdecod_bm.sv
// Directed bench for hqc_rsdecod_bm (PARAM_SECURITY=128, DELTA=15): latency, locator values, reset abort, start filtering.
module tb_hqc_rsdecod_bm;

  localparam int D     = 15;
  localparam int NS    = 2 * D;
  localparam int SYN_W = 16 * D;
  localparam int SIG_W = 8 * (D + 1);
  localparam int LAT   = NS * (D + 3);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [SYN_W-1:0] syn = '0;
  logic             busy, done;
  logic [SIG_W-1:0] sigma;
`ifdef HQC_BM_DEG_OUT_EN
  logic [7:0]       deg;
  logic             fail;
`endif

  int               nvec = 0;
  int               nerr = 0;
  logic [SIG_W-1:0] last_sig = SIG_W'(1);

  hqc_rsdecod_bm #(.PARAM_SECURITY(128)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .syn_i   (syn),
    .start_i (start),
    .busy_o  (busy),
    .sigma_o (sigma),
    .done_o  (done)
`ifdef HQC_BM_DEG_OUT_EN
    ,
    .deg_o   (deg),
    .fail_o  (fail)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [SIG_W-1:0] obs, input logic [SIG_W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [SYN_W-1:0] mk_const(input logic [7:0] b);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int k = 1; k <= NS; k++) s[8*k-1 -: 8] = b;
    return s;
  endfunction

  // Error value 1 at position 1 (S_k = 2^k), optionally plus value 1 at position 0.
  function automatic logic [SYN_W-1:0] mk_pos1(input bit add_pos0);
    logic [SYN_W-1:0] s;
    logic [7:0]       p;
    s = '0;
    p = 8'h01;
    for (int k = 1; k <= NS; k++) begin
      p = xt(p);
      s[8*k-1 -: 8] = p ^ (add_pos0 ? 8'h01 : 8'h00);
    end
    return s;
  endfunction

  task automatic run(input string tag, input logic [SYN_W-1:0] s, input logic [SIG_W-1:0] exp,
                     input logic [7:0] exp_deg, input bit repulse);
    int cyc;
    int nbusy;
    syn   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    syn   = '1;
    cyc   = 1;
    nbusy = 0;
    chk({tag, "_busy1"}, SIG_W'(busy), SIG_W'(1));
    chk({tag, "_hold"}, sigma, last_sig);
    while (!done && cyc < 2000) begin
      if (busy) nbusy++;
      if (repulse && cyc == 100) begin
        syn   = mk_const(8'h05);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_donecyc"}, SIG_W'(cyc), SIG_W'(LAT + 1));
    chk({tag, "_busycnt"}, SIG_W'(nbusy), SIG_W'(LAT));
    chk({tag, "_busydone"}, SIG_W'(busy), SIG_W'(0));
    chk({tag, "_sigma"}, sigma, exp);
`ifdef HQC_BM_DEG_OUT_EN
    chk({tag, "_deg"}, SIG_W'(deg), SIG_W'(exp_deg));
    chk({tag, "_fail"}, SIG_W'(fail), SIG_W'(0));
`endif
    last_sig = exp;
    tick();
    chk({tag, "_donepulse"}, SIG_W'(done), SIG_W'(0));
  endtask

  initial begin
    int ndone;
    repeat (3) tick();
    chk("rst_busy", SIG_W'(busy), SIG_W'(0));
    chk("rst_done", SIG_W'(done), SIG_W'(0));
    chk("rst_sigma", sigma, SIG_W'(1));
    rst = 1'b0;
    tick();

    run("zero", '0, SIG_W'(8'h01), 8'd0, 1'b0);
    run("pos0", mk_const(8'h01), SIG_W'(16'h0101), 8'd1, 1'b0);
    run("pos1_repulse", mk_pos1(1'b0), SIG_W'(16'h0201), 8'd1, 1'b1);
    run("b2b_val5", mk_const(8'h05), SIG_W'(16'h0101), 8'd1, 1'b0);
    run("two_err", mk_pos1(1'b1), SIG_W'(24'h020301), 8'd2, 1'b0);

    syn   = mk_const(8'h01);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (199) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", SIG_W'(busy), SIG_W'(0));
    chk("abort_done", SIG_W'(done), SIG_W'(0));
    chk("abort_sigma", sigma, SIG_W'(1));
    ndone = 0;
    repeat (LAT + 60) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_nodone", SIG_W'(ndone), SIG_W'(0));
    last_sig = SIG_W'(1);
    run("after_abort", mk_pos1(1'b0), SIG_W'(16'h0201), 8'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
